burst_signal_gen: RTL
=====================

Name: burst_signal_gen

Overview:
- Parametrised successor to the two-output noise-test signal generator.
- One clock drives everything. The slow timebase comes from an internal tick prescaler, so there is no second clock input.
- A start edge launches a fixed-length burst. During the burst, NUM_CH phase-staggered square-wave outputs run, with a shared tick counter and an enable flag.
- Sits between the tester control logic and the output drivers of the DUT-stimulus path.

Parameters:
- CLK_DIV, 500, clk cycles per tick (50 MHz -> 100 kHz); must be >= 2.
- CNT_W, 10, width of the burst counter and half_per.
- BURST_LEN, 1000, ticks per burst; must be <= 2**CNT_W.
- NUM_CH, 2, number of square-wave output channels; range 1..8.

Ports:
- clk  in  1  system clock, 50 MHz nominal.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  synchronous to clk; a rising edge requests a burst.
- half_per  in  CNT_W  half-period of channel 0, in ticks; latched at burst launch.
- enable  out  1  high while a burst runs.
- out  out  NUM_CH  channel outputs.
- count  out  CNT_W  tick index within the current burst.
- done  out  1  one-clk pulse at burst end.

Behaviour:
- Reset (async assert, sync release): state=IDLE; enable=0, out=0, count=0, done=0; prescaler=0.
- Prescaler:
  - Free-running 0..CLK_DIV-1.
  - tick=1 for one clk when prescaler==CLK_DIV-1.
  - It is never reset by start.
- Start detect: start_q registered; edge = start & ~start_q. Edge in IDLE or DONE -> ARM. Edges in ARM or RUN are ignored (no retrigger, no queueing).
- ARM:
  - Latch hp = (half_per==0) ? 1 : half_per.
  - Wait for the next tick.
  - On that tick -> RUN, registered in the same edge: enable=1, count=0, phase counter=0, out[0]=1.
- RUN, per tick:
  - phase counter += 1.
  - When phase counter reaches hp-1: out[0] toggles and the phase counter clears.
  - count += 1.
  - When count==BURST_LEN-1 on a tick -> DONE.
- Channel staggering:
  - Per-tick history shift register, NUM_CH-1 deep, shifts on tick only.
  - out[i] (i>=1) = out[0] delayed by i ticks. It starts at 0 and its first rise is i ticks after burst start.
- DONE (one clk):
  - done=1, enable=0, out=0, count holds its final value BURST_LEN-1.
  - Next clk -> IDLE, done=0.
  - An edge seen in DONE goes directly to ARM.
- IDLE: count holds its last value until the next launch clears it.
- Widths:
  - count wraps modulo 2**CNT_W, but never reaches the wrap because BURST_LEN <= 2**CNT_W.
  - The phase counter is CNT_W bits.
- Outputs are all registered; no combinational paths from inputs.
- Launch latency: start edge -> enable high at the first tick after the edge registers, so 1..CLK_DIV+1 clks.
- Reset asserted mid-burst: immediate return to the reset values; no done pulse.

Optional Feature:
- Macro: BURST_NOISE_LFSR_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded 16'hACE1 at reset and at each burst launch.
  - Advances once per tick in RUN.
  - out[NUM_CH-1] = LFSR bit 0 during RUN, 0 otherwise, replacing that channel's delayed square wave.
- Undefined: no LFSR logic; all channels are square waves as above.

Decomposition:
- Package burst_gen_pkg holds:
  - state enum (IDLE, ARM, RUN, DONE);
  - LFSR_SEED = 16'hACE1 and the tap mask;
  - function clamp_hp.
- One sub-module, tick_prescaler (CLK_DIV parameter, outputs tick), is natural and reused by other tester blocks.
- The LFSR stays inline.

Test Plan:
- Reset, CLK_DIV=4, BURST_LEN=16, NUM_CH=2, half_per=2: hold rst_n=0, then pulse start -> enable rises within 5 clks of the edge. out[0] pattern over ticks 0..15 is 1,1,0,0 repeated. out[1] equals out[0] delayed by one tick. count runs 0..15. done pulses once, 4 clks after the count=15 tick. enable=0 after done.
- half_per=0, BURST_LEN=8 -> behaves as half_per=1: out[0] toggles every tick, 1,0,1,0,...
- Start edge mid-RUN at count=5 -> ignored; burst length stays 16 ticks; exactly one done pulse.
- Start edge during the DONE clk -> new burst launches; count restarts at 0; second done pulse 16 ticks later.
- rst_n low at count=7 -> same clk: enable=0, out=0, count=0; no done pulse; a later start launches normally.
- With BURST_NOISE_LFSR_EN, NUM_CH=2: out[1] over the first 4 ticks equals bit 0 of successive LFSR states from 16'hACE1, matched against the reference model. The same sequence repeats on the second burst.

Source files
------------

// File: rtl/burst_gen_pkg.sv
// Shared types and constants for the burst signal generator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package burst_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Fibonacci LFSR, taps 16,14,13,11 expressed as a right-shift mask
    // over bits 0,2,3,5; the feedback bit enters at bit 15.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // A half-period of zero is meaningless, so it runs as one tick.
    function automatic logic [31:0] clamp_hp(input logic [31:0] hp);
        return (hp == 32'd0) ? 32'd1 : hp;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-clk tick every CLK_DIV clks (CLK_DIV >= 2).
// Latency: tick is high while the registered count sits at CLK_DIV-1.
// Backpressure: none; it never stalls and nothing restarts it but reset.
//
// Ports: clk, rst_n (async active-low), tick (one-clk strobe).
module tick_prescaler #(
    parameter int CLK_DIV = 500
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            PW  = $clog2(CLK_DIV);
    localparam logic [PW-1:0] TOP = PW'(CLK_DIV - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == TOP) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    assign tick = (cnt == TOP);

endmodule

// File: rtl/burst_signal_gen.sv
// Burst generator: a start edge launches BURST_LEN ticks of NUM_CH staggered square waves.
// Latency: enable rises on the first tick after the edge registers (1..CLK_DIV+1 clks).
// Backpressure: none; start edges during ARM/RUN are dropped, not queued.
//
// Ports: clk, rst_n (async active-low), start (rising edge requests a burst),
//        half_per (channel-0 half-period in ticks, latched at launch),
//        enable (burst running), out[NUM_CH] (channels), count (tick index),
//        done (one-clk pulse at burst end). All outputs are registered.
// Optional macro BURST_NOISE_LFSR_EN: out[NUM_CH-1] carries LFSR bit 0 instead
// of its delayed square wave. CNT_W must not exceed 32.
module burst_signal_gen #(
    parameter int CLK_DIV   = 500,
    parameter int CNT_W     = 10,
    parameter int BURST_LEN = 1000,
    parameter int NUM_CH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  half_per,
    output logic              enable,
    output logic [NUM_CH-1:0] out,
    output logic [CNT_W-1:0]  count,
    output logic              done
);

    import burst_gen_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic              tick;
    logic              start_q;
    logic              start_edge;
    logic              arm_entry;
    logic              launch;
    logic              run_step;
    logic [CNT_W-1:0]  hp_q;
    logic [CNT_W-1:0]  phase;
    logic              wave0;
    logic [NUM_CH-1:0] wave;

    tick_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign start_edge = start & ~start_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        arm_entry = 1'b0;
        launch    = 1'b0;
        run_step  = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nxt = ARM;
                    arm_entry = 1'b1;
                end
            end
            ARM: begin
                if (tick) begin
                    state_nxt = RUN;
                    launch    = 1'b1;
                end
            end
            RUN: begin
                if (tick) begin
                    if (count == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        run_step = 1'b1;
                    end
                end
            end
            DONE: begin
                // Back-to-back bursts: an edge in the done clk re-arms directly.
                if (start_edge) begin
                    state_nxt = ARM;
                    arm_entry = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    // Outputs are registered from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            hp_q    <= CNT_W'(1);
            enable  <= 1'b0;
            done    <= 1'b0;
            count   <= '0;
            phase   <= '0;
            wave0   <= 1'b0;
        end else begin
            start_q <= start;
            enable  <= (state_nxt == RUN);
            done    <= (state_nxt == DONE);
            if (arm_entry) begin
                hp_q <= CNT_W'(clamp_hp(32'(half_per)));
            end
            if (launch) begin
                count <= '0;
                phase <= '0;
                wave0 <= 1'b1;
            end else if (run_step) begin
                count <= count + CNT_W'(1);
                if (phase == hp_q - CNT_W'(1)) begin
                    wave0 <= ~wave0;
                    phase <= '0;
                end else begin
                    phase <= phase + CNT_W'(1);
                end
            end else if (state_nxt != RUN) begin
                // count deliberately holds outside a burst
                wave0 <= 1'b0;
            end
        end
    end

    // ---------------- channel staggering ----------------
    // hist[j] is channel 0 as it was j+1 ticks ago within the current burst.
    generate
        if (NUM_CH > 1) begin : g_hist
            logic [NUM_CH-2:0] hist;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hist <= '0;
                end else if (launch) begin
                    hist <= '0;
                end else if (run_step) begin
                    hist[0] <= wave0;
                    for (int j = 1; j < NUM_CH - 1; j++) begin
                        hist[j] <= hist[j-1];
                    end
                end else if (state_nxt != RUN) begin
                    hist <= '0;
                end
            end

            assign wave = {hist, wave0};
        end else begin : g_single
            assign wave = wave0;
        end
    endgenerate

`ifdef BURST_NOISE_LFSR_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic        noise;

    assign lfsr_nxt = {^(lfsr & LFSR_TAPS), lfsr[15:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr  <= LFSR_SEED;
            noise <= 1'b0;
        end else if (launch) begin
            lfsr  <= LFSR_SEED;
            noise <= LFSR_SEED[0];
        end else if (run_step) begin
            lfsr  <= lfsr_nxt;
            noise <= lfsr_nxt[0];
        end else if (state_nxt != RUN) begin
            noise <= 1'b0;
        end
    end

    always_comb begin
        out             = wave;
        out[NUM_CH-1]   = noise;
    end
`else
    assign out = wave;
`endif

endmodule
